// File: rtl/handshake_pkg.sv
// Shared helpers for arbitrated handshake units: width math and the default
// constant emitted by constant-producing channels.
package handshake_pkg;

  localparam logic [31:0] DEFAULT_CONST = 32'h0001EFF2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // A single requester still needs a one-bit index.
  function automatic int tag_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/handshake_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// ascending and wrapping modulo NUM_REQ.
module handshake_rr_picker
  import handshake_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = tag_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [TAG_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt_onehot,
  output logic [TAG_WIDTH-1:0] gnt_idx,
  output logic                 any
);

  function automatic int wrap_idx(input int p, input int off);
    return (p + off) % NUM_REQ;
  endfunction

  // Scan from the farthest offset down so the closest match to ptr wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[wrap_idx(int'(ptr), off)]) begin
        any     = 1'b1;
        gnt_idx = TAG_WIDTH'(wrap_idx(int'(ptr), off));
      end
    end
  end

  assign gnt_onehot = any ? (NUM_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/handshake_constant_arbiter.sv
// Shares one constant-producing output slot among NUM_REQ control requesters;
// the round-robin winner's constant is registered together with its index.
module handshake_constant_arbiter
  import handshake_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_VALUES =
    {NUM_REQ{DATA_WIDTH'(DEFAULT_CONST)}},
  localparam int TAG_WIDTH = tag_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [TAG_WIDTH-1:0]  outs_tag,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. ctrl_ready may follow ctrl_valid/outs_ready combinationally,
  // so requesters must never derive ctrl_valid from ctrl_ready.

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q,   out_tag_d;
  logic [TAG_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;

  logic                  load_en;
  logic [NUM_REQ-1:0]    gnt_onehot;
  logic [TAG_WIDTH-1:0]  gnt_idx;
  logic                  gnt_any;

  handshake_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_picker (
    .req       (ctrl_valid),
    .ptr       (rr_ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any       (gnt_any)
  );

  // The slot can be refilled whenever it is empty or being drained this cycle.
  assign load_en = !out_valid_q || outs_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = CONST_VALUES[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        out_tag_d  = gnt_idx;
        rr_ptr_d   = (gnt_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign ctrl_ready = (load_en && gnt_any && !rst) ? gnt_onehot : '0;
  assign outs       = out_data_q;
  assign outs_tag   = out_tag_q;
  assign outs_valid = out_valid_q;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Bench for handshake_constant_arbiter: directed scenarios plus random traffic,
// checked against a queue-based round-robin reference model.
module tb_handshake_constant_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 2;
  localparam int W          = TAG_WIDTH + DATA_WIDTH;
  localparam logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS =
    {32'h00000033, 32'h00000022, 32'h00000011, 32'h0001EFF2};

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    ctrl_valid = '0;
  logic [NUM_REQ-1:0]    ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic [TAG_WIDTH-1:0]  outs_tag;
  logic                  outs_valid;
  logic                  outs_ready = 1'b0;

  always #5 clk = ~clk;

  handshake_constant_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_WIDTH  (DATA_WIDTH),
    .CONST_VALUES(CONSTS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .outs      (outs),
    .outs_tag  (outs_tag),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );

  // Reference model state: the slot contents live in exp_q.
  logic [DATA_WIDTH-1:0] ref_const [NUM_REQ] = '{32'h0001EFF2, 32'h11, 32'h22, 32'h33};
  logic [W-1:0] exp_q[$];
  int  m_ptr       = 0;
  bit  m_out_valid = 1'b0;
  int  m_gnt       = -1;
  int  checks      = 0;
  int  passes      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int ref_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Model: on each edge decide the winner from the architectural rules.
  initial begin : model
    int g;
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (!m_out_valid || outs_ready) begin
          g     = ref_pick(ctrl_valid, m_ptr);
          m_gnt = g;
          if (g >= 0) begin
            exp_q.push_back({TAG_WIDTH'(g), ref_const[g]});
            m_ptr       = (g + 1) % NUM_REQ;
            m_out_valid = 1'b1;
          end else begin
            m_out_valid = 1'b0;
          end
        end else begin
          m_gnt = -1;
        end
      end
    end
  end

  // Monitor: compare grants and the presented token mid-cycle.
  initial begin : monitor
    int p;
    logic [NUM_REQ-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p       = ref_pick(ctrl_valid, m_ptr);
        exp_rdy = ((!m_out_valid || outs_ready) && p >= 0) ? NUM_REQ'(1 << p) : '0;
        check("ctrl_ready", 64'(ctrl_ready), 64'(exp_rdy));
        check("outs_valid", 64'(outs_valid), 64'(m_out_valid));
        if (m_out_valid) begin
          if (exp_q.size() == 0) begin
            check("token_expected", 64'(0), 64'(1));
          end else begin
            check("token", 64'({outs_tag, outs}), 64'(exp_q[0]));
            if (outs_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic [NUM_REQ-1:0] v, input logic r);
    ctrl_valid = v;
    outs_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NUM_REQ-1:0] pending;
    ctrl_valid = 4'b1111;
    outs_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_valid", 64'(outs_valid), 64'(0));
    check("reset_outs", 64'(outs), 64'(0));
    check("reset_outs_tag", 64'(outs_tag), 64'(0));
    check("reset_ctrl_ready", 64'(ctrl_ready), 64'(0));
    ctrl_valid = '0;
    rst = 1'b0;

    // All four valid: strict rotation 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1);
      check("rotation_tag", 64'(outs_tag), 64'(i % NUM_REQ));
    end
    step(4'b0000, 1'b1);

    // Single requester 2 at full throughput.
    repeat (5) step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    // Stall with tag 1 held while requesters 0 and 3 wait, then 3 wins.
    step(4'b0010, 1'b1);
    repeat (3) begin
      step(4'b1001, 1'b0);
      check("stall_outs", 64'(outs), 64'(32'h11));
    end
    step(4'b1001, 1'b1);
    check("after_stall_tag", 64'(outs_tag), 64'(3));
    step(4'b0001, 1'b1);

    // Drain, then confirm the pointer survived idle cycles.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("drained", 64'(outs_valid), 64'(0));
    step(4'b1111, 1'b1);
    check("post_drain_tag", 64'(outs_tag), 64'(1));
    step(4'b0000, 1'b1);

    // Wrap: pointer at 3, grant 3 then 0.
    step(4'b0100, 1'b1);
    step(4'b1001, 1'b1);
    check("wrap_tag3", 64'(outs_tag), 64'(3));
    step(4'b0001, 1'b1);
    check("wrap_tag0", 64'(outs_tag), 64'(0));
    step(4'b0010, 1'b1);
    check("wrap_ptr_is_1", 64'(outs_tag), 64'(1));

    // Asynchronous reset with a buffered token.
    step(4'b1111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(outs_valid), 64'(0));
    check("async_rst_ready", 64'(ctrl_ready), 64'(0));
    exp_q.delete();
    m_out_valid = 1'b0;
    m_ptr       = 0;
    m_gnt       = -1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    step(4'b1111, 1'b1);
    check("post_rst_outs", 64'(outs), 64'(32'h0001EFF2));
    check("post_rst_tag", 64'(outs_tag), 64'(0));
    step(4'b0000, 1'b1);

    // Random traffic: requests stay asserted until the model grants them.
    pending = '0;
    repeat (300) begin
      pending |= NUM_REQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      step(pending, $urandom_range(0, 3) != 0);
      if (m_gnt >= 0) pending[m_gnt] = 1'b0;
    end

    repeat (3) step(4'b0000, 1'b1);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
